mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports: clk  input  1  system clock; reset  input  1  synchronous, active-high reset.
REQ-002 SHALL have fetch-requester ports: i_req  input  1  fetch request; i_addr  input  32  fetch address; i_ack  output  1  fetch done pulse; i_rdata  output  32  fetched word.
REQ-003 SHALL have data-requester ports: d_req  input  1  data request; d_we  input  1  store; d_addr  input  32  address; d_width  input  2  size (00 byte, 01 half, 10 word); d_usignext  input  1  zero-extend load; d_wdata  input  32  store data; d_ack  output  1  done pulse; d_rdata  output  32  load data.
REQ-004 SHALL have shared-memory ports: m_we  output  1; m_address  output  32; m_width  output  2; m_usignext  output  1; m_w_data  output  32; m_r_data  input  32 (combinational read, write on clk rising edge).
REQ-005 SHALL have pause  output  1  asserted while any request is outstanding and not acked this cycle.

Function
REQ-006 SHALL implement FSM states IDLE, GNT_I, GNT_D, encoded in a 2-bit state register.
REQ-007 SHALL, in IDLE or at the end of any GNT state, go to GNT_D if d_req, else GNT_I if i_req, else IDLE (fixed data priority).
REQ-008 SHALL, in GNT_I, drive m_address=i_addr, m_width=10, m_usignext=0, m_we=0, m_w_data=0.
REQ-009 SHALL, in GNT_D, drive m_address=d_addr, m_width=d_width, m_usignext=d_usignext, m_we=d_we, m_w_data=d_wdata.
REQ-010 SHALL, in IDLE, drive m_we=0 and all other memory outputs 0.
REQ-011 SHALL, at the end of GNT_I, register m_r_data into i_rdata and assert i_ack for exactly the next cycle; likewise for GNT_D into d_rdata/d_ack (stores return d_rdata unchanged).
REQ-012 SHALL give a minimum req-to-ack latency of 2 cycles from IDLE; back-to-back grants SHALL have no idle cycle between them.
REQ-013 SHALL hold i_rdata/d_rdata stable until the next ack of the same requester.
REQ-014 SHALL, when a requester's req is asserted in the same cycle its ack is high, treat it as a new request (requesters drop req on ack if finished).
REQ-015 SHALL, if a requester drops req during its own grant, still complete the access and pulse ack.
REQ-016 SHALL never assert i_ack and d_ack in the same cycle.
REQ-017 SHALL compute pause = (i_req & ~i_ack) | (d_req & ~d_ack), combinationally.

Reset
REQ-018 SHALL, on reset, force state IDLE, i_ack=0, d_ack=0, i_rdata=0, d_rdata=0, priority pointer to data, m_we=0 in that same cycle.
REQ-019 SHALL abort any in-flight access when reset is asserted mid-grant: no write commits and no ack is issued afterward.

Configuration
REQ-020 SHALL, with macro MEM_ARB_ROUND_ROBIN_EN defined, replace REQ-007 priority with round-robin: when both request, grant the requester not granted most recently; a single requester is granted immediately.
REQ-021 SHALL, without MEM_ARB_ROUND_ROBIN_EN, use fixed data priority, allowing fetch starvation under continuous d_req.

Verification
REQ-022 Reset then i_req=1, i_addr=0x00000010, m_r_data=0x00A00093 -> GNT_I next cycle, i_ack=1 and i_rdata=0x00A00093 the cycle after, pause=1 until ack.
REQ-023 d_req=1, d_we=1, d_addr=0x100, d_width=10, d_wdata=0xDEADBEEF -> m_we=1 for exactly one cycle with m_address=0x100, then d_ack=1, i_ack=0.
REQ-024 i_req and d_req both high from IDLE, fixed priority -> GNT_D then GNT_I back-to-back, d_ack cycle 2, i_ack cycle 3.
REQ-025 With MEM_ARB_ROUND_ROBIN_EN, both held high for 6 grants -> grant order D,I,D,I,D,I, with no two consecutive acks to the same requester.
REQ-026 reset asserted during GNT_D store to 0x200 -> no m_we, no d_ack, state IDLE next cycle, memory at 0x200 unchanged.
REQ-027 d_req byte load, d_width=00, d_usignext=1, addr 0x203 -> m_width=00, m_usignext=1 during GNT_D, d_rdata equals m_r_data sampled.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: one shared single-cycle memory port arbitrated between an
// instruction-fetch requester (i_*) and a load/store requester (d_*).
// Each grant occupies the memory bus for one cycle. The read data is
// registered at the end of that cycle, and the ack pulses in the next cycle.
// Build option: define MEM_ARB_ROUND_ROBIN_EN to replace fixed data-first
// priority with round-robin between the two requesters.
module mem_arbiter (
  input  logic        clk,
  input  logic        reset,
  // fetch requester
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  // data requester
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [1:0]  d_width,
  input  logic        d_usignext,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  // shared memory
  output logic        m_we,
  output logic [31:0] m_address,
  output logic [1:0]  m_width,
  output logic        m_usignext,
  output logic [31:0] m_w_data,
  input  logic [31:0] m_r_data,
  output logic        pause
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  localparam int REQ_I = 0;
  localparam int REQ_D = 1;

  state_t      state_reg, state_next;
  logic        i_ack_reg, d_ack_reg;
  logic [31:0] i_rdata_reg, d_rdata_reg;
  logic [1:0]  req_vec;
  logic [1:0]  serving;
  logic [1:0]  cand;

  assign req_vec[REQ_I] = i_req;
  assign req_vec[REQ_D] = d_req;
  assign serving[REQ_I] = (state_reg == GNT_I);
  assign serving[REQ_D] = (state_reg == GNT_D);

  // A requester keeps req high during its own grant, because it has not seen
  // the ack yet. That req belongs to the access now finishing, so it is masked
  // out. Otherwise the same access would be granted twice.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cand
      assign cand[gi] = req_vec[gi] & ~serving[gi];
    end
  endgenerate

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Set when data should win the next tie; it flips to the other requester
  // after every grant.
  logic prio_d_reg, prio_d_next;

  // Round-robin pointer register; after reset, data wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_d_reg <= 1'b1;
    end else begin
      prio_d_reg <= prio_d_next;
    end
  end
`endif

  // Next grant decision, taken at every cycle boundary.
  always_comb begin
    state_next = IDLE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    prio_d_next = prio_d_reg;
    if (cand[REQ_D] && cand[REQ_I]) begin
      state_next = prio_d_reg ? GNT_D : GNT_I;
    end else if (cand[REQ_D]) begin
      state_next = GNT_D;
    end else if (cand[REQ_I]) begin
      state_next = GNT_I;
    end
    if (state_next == GNT_D) begin
      prio_d_next = 1'b0;
    end else if (state_next == GNT_I) begin
      prio_d_next = 1'b1;
    end
`else
    if (cand[REQ_D]) begin
      state_next = GNT_D;
    end else if (cand[REQ_I]) begin
      state_next = GNT_I;
    end
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Memory bus mux. The bus is forced quiet while reset is high, so a store
  // caught mid-grant never commits on the reset edge.
  always_comb begin
    m_we       = 1'b0;
    m_address  = 32'd0;
    m_width    = 2'b00;
    m_usignext = 1'b0;
    m_w_data   = 32'd0;
    if (!reset) begin
      case (state_reg)
        GNT_I: begin
          m_address = i_addr;
          m_width   = 2'b10;
        end
        GNT_D: begin
          m_we       = d_we;
          m_address  = d_addr;
          m_width    = d_width;
          m_usignext = d_usignext;
          m_w_data   = d_wdata;
        end
        default: begin
        end
      endcase
    end
  end

  // Completion: capture read data and pulse the ack one cycle after the grant.
  // rdata holds until that requester's next completion; stores keep d_rdata.
  always_ff @(posedge clk) begin
    if (reset) begin
      i_ack_reg   <= 1'b0;
      d_ack_reg   <= 1'b0;
      i_rdata_reg <= 32'd0;
      d_rdata_reg <= 32'd0;
    end else begin
      i_ack_reg <= (state_reg == GNT_I);
      d_ack_reg <= (state_reg == GNT_D);
      if (state_reg == GNT_I) begin
        i_rdata_reg <= m_r_data;
      end
      if ((state_reg == GNT_D) && !d_we) begin
        d_rdata_reg <= m_r_data;
      end
    end
  end

  assign i_ack   = i_ack_reg;
  assign d_ack   = d_ack_reg;
  assign i_rdata = i_rdata_reg;
  assign d_rdata = d_rdata_reg;

  // Stall a requester whose request is waiting and is not completing now.
  assign pause = (i_req & ~i_ack_reg) | (d_req & ~d_ack_reg);

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios, then randomized requesters,
// checked every cycle against a transaction-level reference model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, i_ack;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_usignext, d_ack;
  logic [1:0]  d_width;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        m_we, m_usignext, pause;
  logic [1:0]  m_width;
  logic [31:0] m_address, m_w_data, m_r_data;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_width(d_width),
    .d_usignext(d_usignext), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .m_we(m_we), .m_address(m_address), .m_width(m_width), .m_usignext(m_usignext),
    .m_w_data(m_w_data), .m_r_data(m_r_data), .pause(pause)
  );

  // Shared memory: 256 words, combinational read, write on the rising edge.
  logic [31:0] mem [0:255];
  assign m_r_data = mem[m_address[9:2]];
  always @(posedge clk) begin
    if (m_we) mem[m_address[9:2]] <= m_w_data;
  end

  // Reference model state.
  // srv = requester whose access is on the bus this cycle: 0 none, 1 fetch, 2 data.
  int          srv;
  int          last_srv;
  logic        e_iack, e_dack;
  logic [31:0] e_irdata, e_drdata;
  logic [31:0] refmem [0:255];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Check one cycle against the model. Then advance the model across the
  // clock edge, and return 1 time unit after that edge.
  task automatic step();
    logic [31:0] ea, ewd;
    logic [1:0]  ew;
    logic        eu, ewe, ci, cd;
    int          nxt;
    @(negedge clk);
    ea = 0; ewd = 0; ew = 0; eu = 0; ewe = 0;
    if (!reset && srv == 1) begin
      ea = i_addr; ew = 2'b10;
    end else if (!reset && srv == 2) begin
      ea = d_addr; ew = d_width; eu = d_usignext; ewe = d_we; ewd = d_wdata;
    end
    check("m_we", m_we, ewe);
    check("m_address", m_address, ea);
    check("m_width", m_width, ew);
    check("m_usignext", m_usignext, eu);
    check("m_w_data", m_w_data, ewd);
    check("i_ack", i_ack, e_iack);
    check("d_ack", d_ack, e_dack);
    check("i_rdata", i_rdata, e_irdata);
    check("d_rdata", d_rdata, e_drdata);
    check("pause", pause, (i_req & ~e_iack) | (d_req & ~e_dack));
    check("ack_excl", i_ack & d_ack, 0);
    if (reset) begin
      srv = 0; e_iack = 0; e_dack = 0; e_irdata = 0; e_drdata = 0; last_srv = 1;
    end else begin
      e_iack = (srv == 1);
      e_dack = (srv == 2);
      if (srv == 1) e_irdata = refmem[ea[9:2]];
      if (srv == 2) begin
        if (ewe) refmem[ea[9:2]] = ewd;
        else     e_drdata = refmem[ea[9:2]];
      end
      // The access that finishes now does not request again.
      ci  = i_req && (srv != 1);
      cd  = d_req && (srv != 2);
      nxt = cd ? 2 : (ci ? 1 : 0);
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (ci && cd) nxt = (last_srv == 2) ? 1 : 2;
      if (nxt != 0) last_srv = nxt;
`endif
      srv = nxt;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_req = 0; i_addr = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_width = 0; d_usignext = 0; d_wdata = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    step();
    reset = 0;
  endtask

  logic [31:0] v;

  initial begin
    reset = 1;
    idle_inputs();
    srv = 0; last_srv = 1; e_iack = 0; e_dack = 0; e_irdata = 0; e_drdata = 0;
    for (int k = 0; k < 256; k++) begin
      mem[k] = $urandom;
      refmem[k] = mem[k];
    end
    @(posedge clk); #1;
    step();
    check("rst_i_ack", i_ack, 0);
    check("rst_d_rdata", d_rdata, 0);
    reset = 0;

    // Single fetch: grant next cycle, ack and data the cycle after.
    mem[4] = 32'h00A00093; refmem[4] = 32'h00A00093;
    i_req = 1; i_addr = 32'h10;
    step();
    check("f_gnt_addr", m_address, 32'h10);
    check("f_pause", pause, 1);
    step();
    check("f_ack", i_ack, 1);
    check("f_rdata", i_rdata, 32'h00A00093);
    i_req = 0;
    step();
    check("f_ack_drop", i_ack, 0);

    // Word store: m_we for exactly one cycle, then d_ack alone.
    d_req = 1; d_we = 1; d_addr = 32'h100; d_width = 2'b10; d_wdata = 32'hDEADBEEF;
    step();
    check("st_we", m_we, 1);
    check("st_addr", m_address, 32'h100);
    step();
    check("st_dack", d_ack, 1);
    check("st_iack", i_ack, 0);
    check("st_we_off", m_we, 0);
    idle_inputs();
    step();
    check("st_mem", mem[64], 32'hDEADBEEF);

    // Both request from IDLE: data first, fetch right behind it.
    do_reset();
    i_req = 1; i_addr = 32'h20;
    d_req = 1; d_addr = 32'h40; d_width = 2'b10;
    step();
    check("both_gnt_d", m_address, 32'h40);
    step();
    check("both_dack", d_ack, 1);
    check("both_gnt_i", m_address, 32'h20);
    d_req = 0;
    step();
    check("both_iack", i_ack, 1);
    check("both_dack_off", d_ack, 0);
    idle_inputs();
    step();

    // Both held high for six grants: the acks alternate D,I,D,I,D,I.
    do_reset();
    i_req = 1; i_addr = 32'h8; d_req = 1; d_addr = 32'hC; d_width = 2'b10;
    step();
    for (int k = 0; k < 6; k++) begin
      step();
      check("alt_dack", d_ack, (k % 2) == 0);
      check("alt_iack", i_ack, (k % 2) == 1);
    end
    idle_inputs();
    step();
    step();

    // Reset during a store grant: no write, no ack, and the bus goes idle.
    v = mem[128];
    d_req = 1; d_we = 1; d_addr = 32'h200; d_width = 2'b10; d_wdata = 32'h12345678;
    step();
    reset = 1;
    d_req = 0;
    #1;
    check("rst_mid_we", m_we, 0);
    step();
    reset = 0;
    check("rst_mid_dack", d_ack, 0);
    check("rst_mid_idle", m_address, 0);
    step();
    check("rst_mid_mem", mem[128], v);
    check("rst_mid_dack2", d_ack, 0);

    // Byte load with zero-extend flag passed through to memory.
    idle_inputs();
    d_req = 1; d_addr = 32'h203; d_width = 2'b00; d_usignext = 1;
    step();
    check("ld_width", m_width, 0);
    check("ld_usext", m_usignext, 1);
    v = mem[128];
    step();
    check("ld_rdata", d_rdata, v);
    idle_inputs();
    step();

    // Random requesters that follow the protocol, with occasional early
    // drops and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if (!i_req) begin
        if ($urandom_range(0, 9) < 4) begin i_req = 1; i_addr = $urandom & 32'h3FF; end
      end else if (i_ack) begin
        if ($urandom_range(0, 1) == 1) i_addr = $urandom & 32'h3FF;
        else i_req = 0;
      end else if ($urandom_range(0, 19) == 0) i_req = 0;
      if (!d_req || d_ack) begin
        if (d_req && $urandom_range(0, 1) == 0) d_req = 0;
        else if ($urandom_range(0, 9) < 5) begin
          d_req = 1; d_we = $urandom_range(0, 1); d_addr = $urandom & 32'h3FF;
          d_width = 2'($urandom_range(0, 2)); d_usignext = $urandom_range(0, 1);
          d_wdata = $urandom;
        end
      end else if ($urandom_range(0, 19) == 0) d_req = 0;
      reset = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
